icw_ocw_write_sequencer: RTL and testbench

//  Command-word write controller for the 8259A. Detects CPU write cycles, decodes A0 and D4/D3.

---
 rtl/icw_ocw_write_sequencer_if.sv | 11 +
 rtl/icw_ocw_write_sequencer.sv | 109 ++++++++++
 tb/tb_icw_ocw_write_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icw_ocw_write_sequencer_if.sv
// icw_ocw_write_sequencer_if: CPU write bus into the 8259A command-word sequencer
// Signals: chip_select_n, write_enable_n (active low), A0 address bit, data_bus_in byte.
// master = CPU side (drives), slave = sequencer side (samples).
interface icw_ocw_write_sequencer_if;
    logic       chip_select_n;
    logic       write_enable_n;
    logic       A0;
    logic [7:0] data_bus_in;
    modport master (output chip_select_n, write_enable_n, A0, data_bus_in);
    modport slave  (input  chip_select_n, write_enable_n, A0, data_bus_in);
endinterface

// File: rtl/icw_ocw_write_sequencer.sv
// icw_ocw_write_sequencer: 8259A ICW1..4 init chain and OCW1..3 write classification
// Ports: clk, reset_n (async, active low), bus (CPU write bus, slave);
//   internal_bus_data = byte of last committed write; write_ICW_1..4 / write_OCW_1..3 one-cycle strobes;
//   init_done = chain complete; level_triggered, single_mode, vector_base, cascade_config,
//   auto_eoi, u8086_mode = latched ICW fields.
// SYNC_INPUTS=1 adds a 2-flop synchronizer on all bus inputs (+2 cycles latency).
module icw_ocw_write_sequencer #(
    parameter bit SYNC_INPUTS = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    icw_ocw_write_sequencer_if.slave        bus,
    output logic [7:0]                      internal_bus_data,
    output logic                            write_ICW_1,
    output logic                            write_ICW_2,
    output logic                            write_ICW_3,
    output logic                            write_ICW_4,
    output logic                            write_OCW_1,
    output logic                            write_OCW_2,
    output logic                            write_OCW_3,
    output logic                            init_done,
    output logic                            level_triggered,
    output logic                            single_mode,
    output logic [4:0]                      vector_base,
    output logic [7:0]                      cascade_config,
    output logic                            auto_eoi,
    output logic                            u8086_mode
);
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
    state_t     state;
    logic       cs_n, wr_n, a0, wr_active, wr_prev, cap_a0, ic4, commit;
    logic [7:0] din, cap_d;

    generate
        if (SYNC_INPUTS) begin : g_sync
            logic [1:0][10:0] s;
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) s <= '0;
                else s <= {s[0], {bus.chip_select_n, bus.write_enable_n, bus.A0, bus.data_bus_in}};
            assign {cs_n, wr_n, a0, din} = s[1];
        end else begin : g_direct
            assign {cs_n, wr_n, a0, din} = {bus.chip_select_n, bus.write_enable_n, bus.A0, bus.data_bus_in};
        end
    endgenerate

    // A write commits on its release edge, using the last value seen while active.
    assign wr_active = ~cs_n & ~wr_n;
    assign commit    = wr_prev & ~wr_active;
    assign init_done = state == READY;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            {wr_prev, cap_a0, cap_d} <= '0;
        end else begin
            wr_prev <= wr_active;
            if (wr_active) {cap_a0, cap_d} <= {a0, din};
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state             <= UNINIT;
            internal_bus_data <= '0;
            {write_ICW_1, write_ICW_2, write_ICW_3, write_ICW_4} <= '0;
            {write_OCW_1, write_OCW_2, write_OCW_3}              <= '0;
            {level_triggered, single_mode, ic4, auto_eoi, u8086_mode} <= '0;
            vector_base       <= '0;
            cascade_config    <= '0;
        end else begin
            {write_ICW_1, write_ICW_2, write_ICW_3, write_ICW_4} <= '0;
            {write_OCW_1, write_OCW_2, write_OCW_3}              <= '0;
            if (commit) begin
                internal_bus_data <= cap_d;
                if (!cap_a0 && cap_d[4]) begin
                    write_ICW_1     <= 1'b1;
                    state           <= WAIT_ICW2;
                    level_triggered <= cap_d[3];
                    single_mode     <= cap_d[1];
                    ic4             <= cap_d[0];
                    auto_eoi        <= 1'b0;
                    u8086_mode      <= 1'b0;
                    cascade_config  <= '0;
                end else if (cap_a0) begin
                    case (state)
                        WAIT_ICW2: begin
                            write_ICW_2 <= 1'b1;
                            vector_base <= cap_d[7:3];
                            state       <= !single_mode ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
                        end
                        WAIT_ICW3: begin
                            write_ICW_3    <= 1'b1;
                            cascade_config <= cap_d;
                            state          <= ic4 ? WAIT_ICW4 : READY;
                        end
                        WAIT_ICW4: begin
                            write_ICW_4 <= 1'b1;
                            auto_eoi    <= cap_d[1];
                            u8086_mode  <= cap_d[0];
                            state       <= READY;
                        end
                        READY:   write_OCW_1 <= 1'b1;
                        default: ;
                    endcase
                end else if (state == READY) begin
                    write_OCW_2 <= ~cap_d[3];
                    write_OCW_3 <= cap_d[3];
                end
            end
        end
endmodule

// File: tb/tb_icw_ocw_write_sequencer.sv
// tb_icw_ocw_write_sequencer: checks unsynchronized and synchronized instances against a queue-based model
module tb_icw_ocw_write_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    icw_ocw_write_sequencer_if bus();

    logic [6:0]  st0, st1;
    logic [7:0]  ibd0, ibd1, cc0, cc1;
    logic [4:0]  vb0, vb1;
    logic        rdy0, rdy1, lt0, lt1, sm0, sm1, ae0, ae1, u0, u1;
    logic [16:0] cfg0, cfg1;
    assign cfg0 = {lt0, sm0, vb0, cc0, ae0, u0, rdy0};
    assign cfg1 = {lt1, sm1, vb1, cc1, ae1, u1, rdy1};

    icw_ocw_write_sequencer #(.SYNC_INPUTS(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus), .internal_bus_data(ibd0),
        .write_ICW_1(st0[6]), .write_ICW_2(st0[5]), .write_ICW_3(st0[4]), .write_ICW_4(st0[3]),
        .write_OCW_1(st0[2]), .write_OCW_2(st0[1]), .write_OCW_3(st0[0]),
        .init_done(rdy0), .level_triggered(lt0), .single_mode(sm0), .vector_base(vb0),
        .cascade_config(cc0), .auto_eoi(ae0), .u8086_mode(u0)
    );

    icw_ocw_write_sequencer #(.SYNC_INPUTS(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus), .internal_bus_data(ibd1),
        .write_ICW_1(st1[6]), .write_ICW_2(st1[5]), .write_ICW_3(st1[4]), .write_ICW_4(st1[3]),
        .write_OCW_1(st1[2]), .write_OCW_2(st1[1]), .write_OCW_3(st1[0]),
        .init_done(rdy1), .level_triggered(lt1), .single_mode(sm1), .vector_base(vb1),
        .cascade_config(cc1), .auto_eoi(ae1), .u8086_mode(u1)
    );

    int checks = 0;
    int errors = 0;
    logic [6:0] obs0 [8];
    logic [6:0] obs1 [8];

    // Reference model: remaining init words are a queue of ICW numbers still owed.
    int         pend[$];
    logic       m_ready, m_ltim, m_sngl, m_aeoi, m_8086;
    logic [4:0] m_vb;
    logic [7:0] m_cas, m_ibd;

    function automatic logic [16:0] mcfg();
        return {m_ltim, m_sngl, m_vb, m_cas, m_aeoi, m_8086, m_ready};
    endfunction

    function automatic void model_reset();
        pend.delete();
        {m_ready, m_ltim, m_sngl, m_aeoi, m_8086} = '0;
        m_vb = '0;
        m_cas = '0;
        m_ibd = '0;
    endfunction

    // Returns expected strobe vector {ICW1..ICW4, OCW1..OCW3}.
    function automatic logic [6:0] model_write(input logic a0, input logic [7:0] d);
        int n;
        m_ibd = d;
        if (!a0 && d[4]) begin
            pend = {2};
            if (!d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
            m_ready = 0; m_ltim = d[3]; m_sngl = d[1];
            m_aeoi = 0; m_8086 = 0; m_cas = 0;
            return 7'b1000000;
        end
        if (pend.size() > 0) begin
            if (!a0) return 7'd0;
            n = pend.pop_front();
            if (n == 2) m_vb = d[7:3];
            if (n == 3) m_cas = d;
            if (n == 4) begin m_aeoi = d[1]; m_8086 = d[0]; end
            if (pend.size() == 0) m_ready = 1;
            return 7'(1 << (7 - n));
        end
        if (!m_ready) return 7'd0;
        if (a0) return 7'b0000100;
        return d[3] ? 7'b0000001 : 7'b0000010;
    endfunction

    // One CPU write: 1-3 active cycles (earlier ones carry junk), release by wr_n or cs_n, 4 observed cycles.
    task automatic cpu_write(input logic a0, input logic [7:0] d, input bit rel_cs);
        int n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.chip_select_n = 1'b0;
            bus.write_enable_n = 1'b0;
            if (i == n - 1) {bus.A0, bus.data_bus_in} = {a0, d};
            else {bus.A0, bus.data_bus_in} = 9'($urandom);
        end
        @(negedge clk);
        if (rel_cs) bus.chip_select_n = 1'b1;
        else bus.write_enable_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs0[i] = st0;
            obs1[i] = st1;
        end
        bus.chip_select_n = 1'b1;
        bus.write_enable_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({st0, ibd0, cfg0} !== '0) begin errors++; $display("FAIL reset sync0: got %h want 0", {st0, ibd0, cfg0}); end
        checks++;
        if ({st1, ibd1, cfg1} !== '0) begin errors++; $display("FAIL reset sync1: got %h want 0", {st1, ibd1, cfg1}); end
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({st0, ibd0, cfg0} !== '0) begin errors++; $display("FAIL post_reset sync0: got %h want 0", {st0, ibd0, cfg0}); end
        checks++;
        if ({st1, ibd1, cfg1} !== '0) begin errors++; $display("FAIL post_reset sync1: got %h want 0", {st1, ibd1, cfg1}); end
    endtask

    task automatic test_chain_ic4();
        logic       a0s [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ds  [3] = '{8'h13, 8'h40, 8'h03};
        logic [6:0] es  [3] = '{7'b1000000, 7'b0100000, 7'b0001000};
        for (int i = 0; i < 3; i++) begin
            cpu_write(a0s[i], ds[i], i[0]);
            void'(model_write(a0s[i], ds[i]));
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs0[j] !== (j == 0 ? es[i] : 7'd0)) begin errors++; $display("FAIL chain4 w%0d sync0 c%0d: got %b want %b", i, j, obs0[j], j == 0 ? es[i] : 7'd0); end
                checks++;
                if (obs1[j] !== (j == 2 ? es[i] : 7'd0)) begin errors++; $display("FAIL chain4 w%0d sync1 c%0d: got %b want %b", i, j, obs1[j], j == 2 ? es[i] : 7'd0); end
            end
            checks++;
            if ({ibd0, cfg0} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL chain4 w%0d cfg0: got %h want %h", i, {ibd0, cfg0}, {m_ibd, mcfg()}); end
            checks++;
            if ({ibd1, cfg1} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL chain4 w%0d cfg1: got %h want %h", i, {ibd1, cfg1}, {m_ibd, mcfg()}); end
        end
        checks++;
        if ({vb0, ae0, u0, rdy0} !== {5'h08, 3'b111}) begin errors++; $display("FAIL chain4 final0: got %h want %h", {vb0, ae0, u0, rdy0}, {5'h08, 3'b111}); end
        checks++;
        if ({vb1, ae1, u1, rdy1} !== {5'h08, 3'b111}) begin errors++; $display("FAIL chain4 final1: got %h want %h", {vb1, ae1, u1, rdy1}, {5'h08, 3'b111}); end
    endtask

    task automatic test_chain_icw3();
        logic       a0s [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ds  [3] = '{8'h10, 8'h20, 8'h04};
        logic [6:0] es  [3] = '{7'b1000000, 7'b0100000, 7'b0010000};
        for (int i = 0; i < 3; i++) begin
            cpu_write(a0s[i], ds[i], ~i[0]);
            void'(model_write(a0s[i], ds[i]));
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs0[j] !== (j == 0 ? es[i] : 7'd0)) begin errors++; $display("FAIL chain3 w%0d sync0 c%0d: got %b want %b", i, j, obs0[j], j == 0 ? es[i] : 7'd0); end
                checks++;
                if (obs1[j] !== (j == 2 ? es[i] : 7'd0)) begin errors++; $display("FAIL chain3 w%0d sync1 c%0d: got %b want %b", i, j, obs1[j], j == 2 ? es[i] : 7'd0); end
            end
            checks++;
            if ({ibd0, cfg0} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL chain3 w%0d cfg0: got %h want %h", i, {ibd0, cfg0}, {m_ibd, mcfg()}); end
            checks++;
            if ({ibd1, cfg1} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL chain3 w%0d cfg1: got %h want %h", i, {ibd1, cfg1}, {m_ibd, mcfg()}); end
        end
        checks++;
        if ({cc0, ae0, rdy0} !== {8'h04, 1'b0, 1'b1}) begin errors++; $display("FAIL chain3 final0: got %h want %h", {cc0, ae0, rdy0}, {8'h04, 2'b01}); end
    endtask

    task automatic test_ocw();
        logic       a0s [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] ds  [3] = '{8'hA5, 8'h20, 8'h0A};
        logic [6:0] es  [3] = '{7'b0000100, 7'b0000010, 7'b0000001};
        for (int i = 0; i < 3; i++) begin
            cpu_write(a0s[i], ds[i], i[0]);
            void'(model_write(a0s[i], ds[i]));
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs0[j] !== (j == 0 ? es[i] : 7'd0)) begin errors++; $display("FAIL ocw w%0d sync0 c%0d: got %b want %b", i, j, obs0[j], j == 0 ? es[i] : 7'd0); end
                checks++;
                if (obs1[j] !== (j == 2 ? es[i] : 7'd0)) begin errors++; $display("FAIL ocw w%0d sync1 c%0d: got %b want %b", i, j, obs1[j], j == 2 ? es[i] : 7'd0); end
            end
            checks++;
            if ({ibd0, ibd1} !== {ds[i], ds[i]}) begin errors++; $display("FAIL ocw w%0d data: got %h want %h", i, {ibd0, ibd1}, {ds[i], ds[i]}); end
        end
    endtask

    task automatic test_ignored();
        logic       a0s [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ds  [6] = '{8'hFF, 8'h20, 8'h11, 8'h48, 8'h13, 8'h08};
        logic [6:0] es  [6] = '{7'd0, 7'd0, 7'b1000000, 7'b0100000, 7'b1000000, 7'd0};
        test_reset();
        for (int i = 0; i < 6; i++) begin
            cpu_write(a0s[i], ds[i], i[0]);
            void'(model_write(a0s[i], ds[i]));
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs0[j] !== (j == 0 ? es[i] : 7'd0)) begin errors++; $display("FAIL ignored w%0d sync0 c%0d: got %b want %b", i, j, obs0[j], j == 0 ? es[i] : 7'd0); end
                checks++;
                if (obs1[j] !== (j == 2 ? es[i] : 7'd0)) begin errors++; $display("FAIL ignored w%0d sync1 c%0d: got %b want %b", i, j, obs1[j], j == 2 ? es[i] : 7'd0); end
            end
            checks++;
            if ({ibd0, cfg0} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL ignored w%0d cfg0: got %h want %h", i, {ibd0, cfg0}, {m_ibd, mcfg()}); end
            checks++;
            if ({ibd1, cfg1} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL ignored w%0d cfg1: got %h want %h", i, {ibd1, cfg1}, {m_ibd, mcfg()}); end
        end
        // write_enable_n low without chip select is not a write
        @(negedge clk);
        bus.write_enable_n = 1'b0;
        {bus.A0, bus.data_bus_in} = {1'b0, 8'h10};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 2) bus.write_enable_n = 1'b1;
            checks++;
            if ({st0, st1} !== '0) begin errors++; $display("FAIL nocs c%0d: got %b want 0", i, {st0, st1}); end
        end
        checks++;
        if ({ibd0, ibd1} !== {m_ibd, m_ibd}) begin errors++; $display("FAIL nocs data: got %h want %h", {ibd0, ibd1}, {m_ibd, m_ibd}); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] e;
        cpu_write(1'b0, 8'h10, 1'b0);
        void'(model_write(1'b0, 8'h10));
        cpu_write(1'b1, 8'h20, 1'b1);
        void'(model_write(1'b1, 8'h20));
        checks++;
        if ({ibd0, cfg0} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL mid pre: got %h want %h", {ibd0, cfg0}, {m_ibd, mcfg()}); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({st0, ibd0, cfg0, st1, ibd1, cfg1} !== '0) begin errors++; $display("FAIL mid async: got %h want 0", {st0, ibd0, cfg0, st1, ibd1, cfg1}); end
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cpu_write(1'b1, 8'h04, 1'b0);
        e = model_write(1'b1, 8'h04);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({obs0[j], obs1[j]} !== {e, e}) begin errors++; $display("FAIL mid after c%0d: got %b want %b", j, {obs0[j], obs1[j]}, {e, e}); end
        end
        checks++;
        if ({cfg0, cfg1} !== {mcfg(), mcfg()}) begin errors++; $display("FAIL mid cfg: got %h want %h", {cfg0, cfg1}, {mcfg(), mcfg()}); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ea, eb, x0, x1;
        cpu_write(1'b0, 8'h12, 1'b0);
        void'(model_write(1'b0, 8'h12));
        cpu_write(1'b1, 8'h08, 1'b0);
        void'(model_write(1'b1, 8'h08));
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin errors++; $display("FAIL b2b ready: got %b want 11", {rdy0, rdy1}); end
        ea = model_write(1'b1, 8'h55);
        eb = model_write(1'b0, 8'h0B);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            x0 = k == 2 ? ea : k == 4 ? eb : 7'd0;
            x1 = k == 4 ? ea : k == 6 ? eb : 7'd0;
            checks++;
            if (st0 !== x0) begin errors++; $display("FAIL b2b sync0 c%0d: got %b want %b", k, st0, x0); end
            checks++;
            if (st1 !== x1) begin errors++; $display("FAIL b2b sync1 c%0d: got %b want %b", k, st1, x1); end
            bus.chip_select_n = 1'b0;
            bus.write_enable_n = !(k == 0 || k == 2);
            {bus.A0, bus.data_bus_in} = k < 2 ? {1'b1, 8'h55} : {1'b0, 8'h0B};
        end
        bus.chip_select_n = 1'b1;
        bus.write_enable_n = 1'b1;
        checks++;
        if ({ibd0, ibd1} !== 16'h0B0B) begin errors++; $display("FAIL b2b data: got %h want 0b0b", {ibd0, ibd1}); end
    endtask

    task automatic test_random();
        logic       a0;
        logic [7:0] d;
        logic [6:0] e;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a0 = 1'b0;
                d = {3'($urandom), 1'b1, 4'($urandom)};
            end else begin
                a0 = 1'($urandom);
                d = 8'($urandom);
            end
            cpu_write(a0, d, 1'($urandom));
            e = model_write(a0, d);
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs0[j] !== (j == 0 ? e : 7'd0)) begin errors++; $display("FAIL rand w%0d sync0 c%0d: got %b want %b", i, j, obs0[j], j == 0 ? e : 7'd0); end
                checks++;
                if (obs1[j] !== (j == 2 ? e : 7'd0)) begin errors++; $display("FAIL rand w%0d sync1 c%0d: got %b want %b", i, j, obs1[j], j == 2 ? e : 7'd0); end
            end
            checks++;
            if ({ibd0, cfg0} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL rand w%0d cfg0: got %h want %h", i, {ibd0, cfg0}, {m_ibd, mcfg()}); end
            checks++;
            if ({ibd1, cfg1} !== {m_ibd, mcfg()}) begin errors++; $display("FAIL rand w%0d cfg1: got %h want %h", i, {ibd1, cfg1}, {m_ibd, mcfg()}); end
        end
    endtask

    initial begin
        bus.chip_select_n = 1'b1;
        bus.write_enable_n = 1'b1;
        bus.A0 = 1'b0;
        bus.data_bus_in = 8'h00;
        test_reset();
        test_chain_ic4();
        test_chain_icw3();
        test_ocw();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
